// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared bus types and constants for the Svarog-1 data responder
// Purpose: responder FSM state type, word size and wait-counter width.
// Ports: none (package).
package svarog_bus_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_BUSY,
        RSP_RESP
    } rsp_state_t;

    localparam int WORD_BYTES = 4;
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core data-port handshake bundle
// Purpose: groups the req/write/addr/wdata -> ready/rdata/err handshake.
// Ports: master = core side (drives request fields), slave = responder side (drives response).
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_i;
    logic                  write_i;
    logic [DATA_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  ready_o;
    logic                  err_o;

    modport master (
        output req_i, write_i, addr_i, wdata_i,
        input  rdata_o, ready_o, err_o
    );

    modport slave (
        input  req_i, write_i, addr_i, wdata_i,
        output rdata_o, ready_o, err_o
    );
endinterface

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - single-port synchronous word RAM
// Purpose: word storage with registered read data.
// Ports: clk_i clock; en access enable; we write enable; addr word index;
//        wdata write word; rdata registered read word (updates only on en && !we).
module dmem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = "",
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    // Storage and read register are deliberately unreset.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                rdata <= r_mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with configurable wait states
// Purpose: target of the core data handshake; captures a request, waits WAIT_STATES
//          cycles, accesses the RAM on RESP entry and pulses ready_o for one cycle.
// Ports: clk_i clock; reset_i synchronous active-high reset;
//        bus (slave modport) request fields in, rdata_o/ready_o/err_o out.
module dmem_responder
    import svarog_bus_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1,
    parameter                        INIT_FILE   = ""
) (
    input  logic             clk_i,
    input  logic             reset_i,
    dmem_responder_if.slave  bus
);

    localparam int                  IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [DATA_WIDTH:0] SPAN  = (DATA_WIDTH+1)'(WORD_BYTES * DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        WAIT_CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    rsp_state_t r_state, w_next;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_write;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_in_range;
    logic                  r_rd_zero;

    logic [DATA_WIDTH-1:0] w_off;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_enter_resp;
    logic                  w_acc_write;
    logic                  w_acc_in_range;
    logic [IDX_W-1:0]      w_acc_idx;
    logic [DATA_WIDTH-1:0] w_acc_wdata;
    logic                  w_ram_en;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Offset compare covers both ends of the window; the index drops the byte lane bits.
    assign w_off      = bus.addr_i - BASE_ADDR;
    assign w_in_range = (bus.addr_i >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
    assign w_idx      = w_off[IDX_W+1:2];

    always_comb begin
        w_next = r_state;
        case (r_state)
            RSP_IDLE: if (bus.req_i) w_next = (WAIT_STATES == 0) ? RSP_RESP : RSP_BUSY;
            RSP_BUSY: if (r_cnt == '0) w_next = RSP_RESP;
            RSP_RESP: w_next = RSP_IDLE;
            default:  w_next = RSP_IDLE;
        endcase
    end

    // With zero wait states the accepting edge is also the RESP entry edge, so the
    // access must use the live request rather than the not-yet-captured copy.
    assign w_enter_resp   = (w_next == RSP_RESP) && (r_state != RSP_RESP);
    assign w_acc_write    = (r_state == RSP_IDLE) ? bus.write_i : r_write;
    assign w_acc_in_range = (r_state == RSP_IDLE) ? w_in_range  : r_in_range;
    assign w_acc_idx      = (r_state == RSP_IDLE) ? w_idx       : r_idx;
    assign w_acc_wdata    = (r_state == RSP_IDLE) ? bus.wdata_i : r_wdata;
    // Reset on the RESP entry edge must suppress the commit.
    assign w_ram_en       = w_enter_resp && w_acc_in_range && !reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= RSP_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_in_range <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == RSP_IDLE && bus.req_i) begin
                r_write    <= bus.write_i;
                r_idx      <= w_idx;
                r_wdata    <= bus.wdata_i;
                r_in_range <= w_in_range;
                r_cnt      <= CNT_LOAD;
            end else if (r_state == RSP_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - WAIT_CNT_W'(1);
            end
            // Only reads move rdata_o; an out-of-range read forces it to zero.
            if (w_enter_resp && !w_acc_write) begin
                r_rd_zero <= !w_acc_in_range;
            end
        end
    end

    dmem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk_i (clk_i),
        .en    (w_ram_en),
        .we    (w_acc_write),
        .addr  (w_acc_idx),
        .wdata (w_acc_wdata),
        .rdata (w_ram_rdata)
    );

    assign bus.ready_o = (r_state == RSP_RESP);
    assign bus.err_o   = (r_state == RSP_RESP) && !r_in_range;
    assign bus.rdata_o = r_rd_zero ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WS_A  = 3;
    localparam int WS_B  = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_WIDTH(32)) bus_a ();
    dmem_responder_if #(.DATA_WIDTH(32)) bus_b ();

    dmem_responder #(
        .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0),
        .WAIT_STATES(WS_A), .INIT_FILE("")
    ) u_dut_a (.clk_i(clk), .reset_i(reset), .bus(bus_a.slave));

    dmem_responder #(
        .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0),
        .WAIT_STATES(WS_B), .INIT_FILE("")
    ) u_dut_b (.clk_i(clk), .reset_i(reset), .bus(bus_b.slave));

    logic        r_req, r_sel, r_write;
    logic [31:0] r_addr, r_wdata;

    assign bus_a.req_i   = r_req & ~r_sel;
    assign bus_a.write_i = r_write;
    assign bus_a.addr_i  = r_addr;
    assign bus_a.wdata_i = r_wdata;
    assign bus_b.req_i   = r_req & r_sel;
    assign bus_b.write_i = r_write;
    assign bus_b.addr_i  = r_addr;
    assign bus_b.wdata_i = r_wdata;

    wire        w_ready = r_sel ? bus_b.ready_o : bus_a.ready_o;
    wire        w_err   = r_sel ? bus_b.err_o   : bus_a.err_o;
    wire [31:0] w_rdata = r_sel ? bus_b.rdata_o : bus_a.rdata_o;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem_m [2][DEPTH];
    logic [31:0] last_rd [2];

    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'(4 * DEPTH);
    endfunction

    function automatic int ws_of(input bit s);
        return s ? WS_B : WS_A;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a >> 2) % DEPTH;
    endfunction

    task automatic model(input bit s, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (in_rng(a)) begin
            if (we) mem_m[s][idx_of(a)] = d;
            else    last_rd[s] = mem_m[s][idx_of(a)];
        end else if (!we) begin
            last_rd[s] = 32'h0;
        end
    endtask

    task automatic txn(input bit s, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input bit scramble, output int lat, output logic [31:0] rd,
                       output logic e, output logic stuck);
        r_sel = s; r_write = we; r_addr = a; r_wdata = d; r_req = 1'b1;
        @(posedge clk); #1;
        if (scramble) begin
            r_write = 1'($urandom); r_addr = $urandom; r_wdata = $urandom;
        end
        lat = 1;
        while (w_ready !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = w_rdata; e = w_err; r_req = 1'b0;
        @(posedge clk); #1;
        stuck = w_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1; r_req = 1'b0; r_sel = 1'b0; r_write = 1'b0; r_addr = '0; r_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus_a.ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready_a got %b want 0", bus_a.ready_o); end
        n_vec++; if (bus_a.err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err_a got %b want 0", bus_a.err_o); end
        n_vec++; if (bus_a.rdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata_a got %h want 0", bus_a.rdata_o); end
        n_vec++; if (bus_b.ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready_b got %b want 0", bus_b.ready_o); end
        n_vec++; if (bus_b.rdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata_b got %h want 0", bus_b.rdata_o); end
        reset = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    endtask

    task automatic test_fill();
        int lat; logic [31:0] rd, d; logic e, st;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                d = $urandom;
                txn(1'(s), 1'b1, 32'(i * 4), d, 1'b0, lat, rd, e, st);
                model(1'(s), 1'b1, 32'(i * 4), d);
                n_vec++; if (lat !== ws_of(1'(s)) + 1 || e !== 1'b0) begin
                    n_bad++; $display("FAIL fill s%0d i%0d lat %0d err %b want lat %0d err 0", s, i, lat, e, ws_of(1'(s)) + 1);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic e, st;
        txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat, rd, e, st);
        model(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        n_vec++; if (lat != 4 || e !== 1'b0 || st !== 1'b0) begin n_bad++; $display("FAIL wr_0x10 lat %0d err %b stuck %b want 4 0 0", lat, e, st); end
        n_vec++; if (rd !== last_rd[0]) begin n_bad++; $display("FAIL wr_hold rdata %h want %h", rd, last_rd[0]); end
        txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, e, st);
        model(1'b0, 1'b0, 32'h10, 32'h0);
        n_vec++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0 || lat != 4) begin n_bad++; $display("FAIL rd_0x10 rdata %h err %b lat %0d want deadbeef 0 4", rd, e, lat); end
        txn(1'b0, 1'b0, 32'h13, 32'h0, 1'b0, lat, rd, e, st);
        model(1'b0, 1'b0, 32'h13, 32'h0);
        n_vec++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin n_bad++; $display("FAIL rd_0x13 rdata %h err %b want deadbeef 0", rd, e); end
    endtask

    task automatic test_wait0();
        int lat; logic [31:0] rd; logic e, st;
        txn(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat, rd, e, st);
        model(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        n_vec++; if (lat != 1 || st !== 1'b0) begin n_bad++; $display("FAIL ws0_wr lat %0d stuck %b want 1 0", lat, st); end
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, e, st);
        model(1'b1, 1'b0, 32'h10, 32'h0);
        n_vec++; if (lat != 1 || rd !== 32'hDEAD_BEEF || st !== 1'b0) begin n_bad++; $display("FAIL ws0_rd lat %0d rdata %h stuck %b want 1 deadbeef 0", lat, rd, st); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd, d; logic e, st;
        for (int s = 0; s < 2; s++) begin
            d = $urandom;
            txn(1'(s), 1'b1, 32'(4 * DEPTH), d, 1'b0, lat, rd, e, st);
            model(1'(s), 1'b1, 32'(4 * DEPTH), d);
            n_vec++; if (e !== 1'b1 || lat != ws_of(1'(s)) + 1) begin n_bad++; $display("FAIL oor_wr s%0d err %b lat %0d want 1 %0d", s, e, lat, ws_of(1'(s)) + 1); end
            txn(1'(s), 1'b0, 32'h0, 32'h0, 1'b0, lat, rd, e, st);
            model(1'(s), 1'b0, 32'h0, 32'h0);
            n_vec++; if (rd !== last_rd[s] || e !== 1'b0) begin n_bad++; $display("FAIL oor_alias s%0d word0 %h err %b want %h 0", s, rd, e, last_rd[s]); end
            txn(1'(s), 1'b0, 32'(4 * DEPTH), 32'h0, 1'b0, lat, rd, e, st);
            model(1'(s), 1'b0, 32'(4 * DEPTH), 32'h0);
            n_vec++; if (rd !== 32'h0 || e !== 1'b1) begin n_bad++; $display("FAIL oor_rd s%0d rdata %h err %b want 0 1", s, rd, e); end
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, a, d; logic e, st; bit s, we;
        for (int n = 0; n < 80; n++) begin
            s  = 1'($urandom);
            we = 1'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
            d  = $urandom;
            txn(s, we, a, d, 1'b1, lat, rd, e, st);
            model(s, we, a, d);
            n_vec++; if (lat != ws_of(s) + 1 || st !== 1'b0) begin n_bad++; $display("FAIL rnd%0d timing lat %0d stuck %b want %0d 0", n, lat, st, ws_of(s) + 1); end
            n_vec++; if (e !== !in_rng(a)) begin n_bad++; $display("FAIL rnd%0d err addr %h got %b want %b", n, a, e, !in_rng(a)); end
            n_vec++; if (rd !== last_rd[s]) begin n_bad++; $display("FAIL rnd%0d rdata addr %h we %b got %h want %h", n, a, we, rd, last_rd[s]); end
        end
    endtask

    task automatic test_back_to_back(input bit s);
        int first_c, second_c, highs, w;
        logic [31:0] rd1, rd2;
        w = ws_of(s);
        first_c = 0; second_c = 0; highs = 0; rd1 = '0; rd2 = '0;
        r_sel = s; r_write = 1'b0; r_addr = 32'h10; r_wdata = '0; r_req = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 3 * (w + 1) + 4; c++) begin
            if (w_ready === 1'b1) begin
                highs++;
                if (first_c == 0) begin first_c = c; rd1 = w_rdata; end
                else if (second_c == 0) begin second_c = c; rd2 = w_rdata; r_req = 1'b0; end
            end
            @(posedge clk); #1;
        end
        r_req = 1'b0;
        model(s, 1'b0, 32'h10, 32'h0);
        model(s, 1'b0, 32'h10, 32'h0);
        n_vec++; if (first_c != w + 1 || second_c != 2 * (w + 1) + 1 || highs != 2) begin
            n_bad++; $display("FAIL b2b s%0d pulses at %0d,%0d count %0d want %0d,%0d count 2", s, first_c, second_c, highs, w + 1, 2 * (w + 1) + 1);
        end
        n_vec++; if (rd1 !== last_rd[s] || rd2 !== last_rd[s]) begin n_bad++; $display("FAIL b2b s%0d rdata %h %h want %h", s, rd1, rd2, last_rd[s]); end
    endtask

    task automatic test_reset_mid();
        int lat, highs; logic [31:0] rd; logic e, st;
        // Reset while BUSY.
        highs = 0;
        r_sel = 1'b0; r_write = 1'b1; r_addr = 32'h20; r_wdata = 32'h1234_5678; r_req = 1'b1;
        @(posedge clk); #1;
        if (w_ready === 1'b1) highs++;
        @(posedge clk); #1;
        if (w_ready === 1'b1) highs++;
        reset = 1'b1; r_req = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bus_a.ready_o !== 1'b0 || bus_a.err_o !== 1'b0 || bus_a.rdata_o !== 32'h0) begin
            n_bad++; $display("FAIL rst_busy outputs ready %b err %b rdata %h want 0 0 0", bus_a.ready_o, bus_a.err_o, bus_a.rdata_o);
        end
        reset = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus_a.ready_o === 1'b1) highs++;
        end
        n_vec++; if (highs != 0) begin n_bad++; $display("FAIL rst_busy ready pulses %0d want 0", highs); end
        txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd, e, st);
        model(1'b0, 1'b0, 32'h20, 32'h0);
        n_vec++; if (rd !== last_rd[0] || e !== 1'b0) begin n_bad++; $display("FAIL rst_busy word 0x20 %h err %b want %h 0", rd, e, last_rd[0]); end

        // Reset on the very edge that would enter RESP.
        highs = 0;
        r_sel = 1'b0; r_write = 1'b1; r_addr = 32'h24; r_wdata = 32'hA5A5_5A5A; r_req = 1'b1;
        for (int c = 0; c < WS_A; c++) begin
            @(posedge clk); #1;
            if (w_ready === 1'b1) highs++;
        end
        reset = 1'b1; r_req = 1'b0;
        @(posedge clk); #1;
        if (bus_a.ready_o === 1'b1) highs++;
        reset = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        @(posedge clk); #1;
        if (bus_a.ready_o === 1'b1) highs++;
        n_vec++; if (highs != 0) begin n_bad++; $display("FAIL rst_edge ready pulses %0d want 0", highs); end
        txn(1'b0, 1'b0, 32'h24, 32'h0, 1'b0, lat, rd, e, st);
        model(1'b0, 1'b0, 32'h24, 32'h0);
        n_vec++; if (rd !== last_rd[0]) begin n_bad++; $display("FAIL rst_edge word 0x24 %h want %h", rd, last_rd[0]); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_wait0();
        test_out_of_range();
        test_random();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
